fft_frame_loader: RTL and testbench

Downstream consumer of the 2:1 width-converting first-word-fall-through sample FIFO in the FFT sample path. Pops one sample per cycle while the FIFO is non-empty, writes each sample into the FFT input frame RAM, then hands the complete frame to the FFT engine with a ready/ack handshake. Bit-reversed write addressing is optional, so the FFT engine can read in natural order.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_frame_loader_if.sv | 25 ++
 rtl/fft_frame_loader_bitrev.sv | 14 +
 rtl/fft_frame_loader.sv | 113 +++++++++++
 tb/tb_fft_frame_loader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sample path: loader state encoding and
// frame bookkeeping constants.
package fft_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_READY = 2'd3
    } loader_state_e;

    localparam int FRAMES_DONE_W = 16;

    function automatic int unsigned frame_len(input int unsigned log2);
        return 32'd1 << log2;
    endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Loader bus: FIFO read side, frame RAM write port and the frame handoff to
// the FFT engine. master = loader, slave = FIFO/RAM/engine side.
interface fft_frame_loader_if #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int FRAME_LOG2   = 8
);
    logic [SAMPLE_WIDTH-1:0] fifo_dout;
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic                    mem_we;
    logic [FRAME_LOG2-1:0]   mem_addr;
    logic [SAMPLE_WIDTH-1:0] mem_wdata;
    logic                    frame_ready;
    logic                    frame_ack;

    modport master (
        input  fifo_dout, fifo_empty, frame_ack,
        output fifo_rd_en, mem_we, mem_addr, mem_wdata, frame_ready
    );

    modport slave (
        output fifo_dout, fifo_empty, frame_ack,
        input  fifo_rd_en, mem_we, mem_addr, mem_wdata, frame_ready
    );
endinterface

// File: rtl/fft_frame_loader_bitrev.sv
// Combinational bit reversal of a frame RAM address. Compiled only when
// FFT_LOADER_BITREV_EN is defined, since only then is it instantiated.
`ifdef FFT_LOADER_BITREV_EN
module bitrev_addr #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] addr_i,
    output logic [WIDTH-1:0] addr_o
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign addr_o[i] = addr_i[WIDTH-1-i];
    end
endmodule
`endif

// File: rtl/fft_frame_loader.sv
// Pops samples from the FWFT FIFO into the FFT frame RAM, then hands the full
// frame to the FFT engine. FFT_LOADER_BITREV_EN selects bit-reversed addressing.
//
// state   | meaning
// IDLE    | waiting for enable; sample counter cleared
// LOAD    | popping one sample per non-empty cycle into the RAM
// FLUSH   | last RAM write on the bus
// READY   | frame resident, waiting for frame_ack
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int FRAME_LOG2   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    output logic [FRAMES_DONE_W-1:0] frames_done_o,
    fft_frame_loader_if.master       bus
);
    localparam int                 CNT_W    = FRAME_LOG2 + 1;
    localparam int unsigned        N        = frame_len(FRAME_LOG2);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N - 1);

    loader_state_e               state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        mem_we_q, mem_we_d;
    logic [FRAME_LOG2-1:0]       mem_addr_q, mem_addr_d;
    logic [SAMPLE_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic                        frame_ready_q, frame_ready_d;
    logic [FRAMES_DONE_W-1:0]    frames_done_q, frames_done_d;
    logic [FRAME_LOG2-1:0]       wr_addr;
    logic                        pop;

`ifdef FFT_LOADER_BITREV_EN
    bitrev_addr #(.WIDTH(FRAME_LOG2)) u_bitrev (
        .addr_i (cnt_q[FRAME_LOG2-1:0]),
        .addr_o (wr_addr)
    );
`else
    assign wr_addr = cnt_q[FRAME_LOG2-1:0];
`endif

    assign pop            = (state_q == S_LOAD) && !bus.fifo_empty;
    assign bus.fifo_rd_en = pop;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.frame_ready = frame_ready_q;
    assign frames_done_o  = frames_done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            frame_ready_q <= 1'b0;
            frames_done_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            frame_ready_q <= frame_ready_d;
            frames_done_q <= frames_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        frames_done_d = frames_done_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                // an empty FIFO simply stalls here with the counter held
                if (pop) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = bus.fifo_dout;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_READY;
            end
            S_READY: begin
                cnt_d = '0;
                if (bus.frame_ack) begin
                    frames_done_d = frames_done_q + FRAMES_DONE_W'(1);
                    state_d       = enable_i ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        frame_ready_d = (state_d == S_READY);
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader with N=8, 8-bit samples; expected write
// addresses follow FFT_LOADER_BITREV_EN.
module tb_fft_frame_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] frames_done;

    fft_frame_loader_if #(.SAMPLE_WIDTH(8), .FRAME_LOG2(3)) lif ();

    fft_frame_loader #(.SAMPLE_WIDTH(8), .FRAME_LOG2(3)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .frames_done_o (frames_done),
        .bus           (lif.master)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] fifo_q[$];
    logic       starve = 1'b0;
    int         cyc = 0;
    int         pops = 0;
    int         last_pop_cyc = 0;
    int         ready_cyc = 0;
    int         rd_empty_cnt = 0;
    int         rd_starve_cnt = 0;
    int         wr_addr_q[$];
    int         wr_data_q[$];
    int         wr_cyc_q[$];
    int         brev_tbl [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive_fifo();
        lif.fifo_empty = starve || (fifo_q.size() == 0);
        lif.fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(base + i));
        drive_fifo();
    endtask

    task automatic clear_rec();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        pops = 0;
    endtask

    task automatic tick();
        logic popped;
        #1;
        popped = lif.fifo_rd_en;
        if (popped && lif.fifo_empty) rd_empty_cnt++;
        if (popped && starve) rd_starve_cnt++;
        @(posedge clk);
        #1;
        if (popped) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pops++;
            last_pop_cyc = cyc;
        end
        cyc++;
        if (lif.mem_we) begin
            wr_addr_q.push_back(int'(lif.mem_addr));
            wr_data_q.push_back(int'(lif.mem_wdata));
            wr_cyc_q.push_back(cyc);
        end
        drive_fifo();
    endtask

    task automatic run_to_ready(input int starve_after, input int starve_len);
        int budget = 60;
        int sleft = 0;
        bit trig = 1'b0;
        while (!lif.frame_ready && budget > 0) begin
            tick();
            if (!trig && pops == starve_after) begin
                trig  = 1'b1;
                starve = 1'b1;
                sleft = starve_len;
                drive_fifo();
            end else if (sleft > 0) begin
                sleft--;
                if (sleft == 0) begin
                    starve = 1'b0;
                    drive_fifo();
                end
            end
            budget--;
        end
        ready_cyc = cyc;
        chk("ready_reached", 32'(budget > 0), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base);
        int exp_addr;
        chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
`ifdef FFT_LOADER_BITREV_EN
            exp_addr = brev_tbl[i];
`else
            exp_addr = i;
`endif
            chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr);
            chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], base + i);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(lif.fifo_rd_en), 32'd0);
        chk({tag, "_we"}, 32'(lif.mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(lif.mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(lif.mem_wdata), 32'd0);
        chk({tag, "_ready"}, 32'(lif.frame_ready), 32'd0);
        chk({tag, "_frames_done"}, 32'(frames_done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        rst           = 1'b1;
        enable        = 1'b0;
        lif.frame_ack = 1'b0;
        drive_fifo();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;

        // idle with a full FIFO must never pop
        push_frame(8'h10);
        clear_rec();
        repeat (20) tick();
        chk("idle_pops", 32'(pops), 32'd0);
        chk("idle_fifo_level", 32'(fifo_q.size()), 32'd8);

        // frame A: back-to-back stream
        clear_rec();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        run_to_ready(-1, 0);
        check_frame("A", 8'h10);
        if (wr_cyc_q.size() == 8)
            chk("A_consecutive", 32'(wr_cyc_q[7] - wr_cyc_q[0]), 32'd7);
        chk("A_ready_latency", 32'(ready_cyc - last_pop_cyc), 32'd2);
        chk("A_ready", 32'(lif.frame_ready), 32'd1);
        lif.frame_ack = 1'b1;
        tick();
        lif.frame_ack = 1'b0;
        chk("A_ack_ready", 32'(lif.frame_ready), 32'd0);
        chk("A_ack_done", 32'(frames_done), 32'd1);

        // frame B: FIFO starves for 5 cycles after the 3rd pop
        push_frame(8'h20);
        tick();
        chk("B_idle_rd_en", 32'(lif.fifo_rd_en), 32'd0);
        clear_rec();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        run_to_ready(3, 5);
        check_frame("B", 8'h20);
        if (wr_cyc_q.size() == 8)
            chk("B_stall_gap", 32'(wr_cyc_q[3] - wr_cyc_q[2]), 32'd6);
        chk("B_rd_while_starved", 32'(rd_starve_cnt), 32'd0);

        // ack and enable together restart loading immediately
        push_frame(8'h50);
        clear_rec();
        lif.frame_ack = 1'b1;
        enable        = 1'b1;
        tick();
        enable = 1'b0;
        chk("B2B_ready", 32'(lif.frame_ready), 32'd0);
        chk("B2B_done", 32'(frames_done), 32'd2);
        chk("B2B_rd_en", 32'(lif.fifo_rd_en), 32'd1);
        tick();
        lif.frame_ack = 1'b0;
        chk("C_ack_in_load", 32'(frames_done), 32'd2);
        run_to_ready(-1, 0);
        check_frame("C", 8'h50);
        chk("C_done_hold", 32'(frames_done), 32'd2);
        lif.frame_ack = 1'b1;
        tick();
        lif.frame_ack = 1'b0;
        chk("C_ack_done", 32'(frames_done), 32'd3);

        // reset after the 5th pop of a frame
        push_frame(8'h30);
        clear_rec();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        budget = 20;
        while (pops < 5 && budget > 0) begin
            tick();
            budget--;
        end
        chk("R_pops_before_rst", 32'(pops), 32'd5);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_q.delete();
        push_frame(8'h40);
        clear_rec();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        run_to_ready(-1, 0);
        check_frame("D", 8'h40);
        chk("D_pops", 32'(pops), 32'd8);
        chk("D_ready_latency", 32'(ready_cyc - last_pop_cyc), 32'd2);

        chk("rd_while_empty", 32'(rd_empty_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
